lsfr_checker: RTL and testbench

Receive-side checker for the Fibonacci LFSR stream produced by `fibonacci_lsfr`. It self-seeds from the incoming words, predicts each next word with the same next-state function, qualifies lock, and then counts mismatches. It sits at the far end of any link or datapath under test that carries LFSR words.

---
 rtl/lsfr_checker.sv | 145 ++++++++++++++
 tb/tb_lsfr_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lsfr_checker.sv
// Receive-side checker for a Fibonacci LFSR word stream: self-seeds, qualifies lock,
// then counts mismatching words with a flywheel predictor.
module lsfr_checker #(
    parameter int                   BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0] TAPS      = BIT_WIDTH'('hB8),
    parameter int                   LOCK_CNT  = 4,
    parameter int                   LOSS_CNT  = 4,
    parameter int                   CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 lsfr_vld,
    input  logic [BIT_WIDTH-1:0] lsfr_data,
    input  logic                 clr_cnt,
    output logic                 lock,
    output logic                 err_vld,
    output logic                 err_flag,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {IDLE, SEED, CHECK, LOCKED} state_t;

    state_t               state, state_n;
    logic [BIT_WIDTH-1:0] pred, pred_n;
    logic [GW-1:0]        good_cnt, good_n;
    logic [BW-1:0]        bad_cnt, bad_n;
    logic                 err_vld_n, err_flag_n;
    logic [CNT_WIDTH-1:0] err_cnt_n, word_cnt_n;
    logic [CNT_WIDTH-1:0] err_base, word_base;
    logic                 flag_base;
    logic                 match;

    function automatic logic [BIT_WIDTH-1:0] nxt(input logic [BIT_WIDTH-1:0] s);
        return {s[BIT_WIDTH-2:0], ^(s & TAPS)};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    // lsfr_vld qualifies lsfr_data for one cycle; there is no backpressure,
    // so every valid word is consumed in the cycle it is presented.
    assign match = (lsfr_data == pred);

    always_comb begin
        state_n    = state;
        pred_n     = pred;
        good_n     = good_cnt;
        bad_n      = bad_cnt;
        err_vld_n  = 1'b0;
        // Clear lands first so a counted word in the same cycle starts from zero.
        err_base   = clr_cnt ? '0 : err_cnt;
        word_base  = clr_cnt ? '0 : word_cnt;
        flag_base  = clr_cnt ? 1'b0 : err_flag;
        err_cnt_n  = err_base;
        word_cnt_n = word_base;
        err_flag_n = flag_base;

        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = SEED;
                SEED: begin
                    if (lsfr_vld && lsfr_data != '0) begin
                        pred_n  = nxt(lsfr_data);
                        good_n  = '0;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (lsfr_vld) begin
                        if (match) begin
                            pred_n = nxt(lsfr_data);
                            if (int'(good_cnt) + 1 == LOCK_CNT) begin
                                good_n  = GW'(LOCK_CNT);
                                bad_n   = '0;
                                state_n = LOCKED;
                            end else begin
                                good_n = good_cnt + GW'(1);
                            end
                        end else if (lsfr_data != '0) begin
                            pred_n = nxt(lsfr_data);
                            good_n = '0;
                        end else begin
                            state_n = SEED;
                        end
                    end
                end
                LOCKED: begin
                    if (lsfr_vld) begin
                        word_cnt_n = sat_inc(word_base);
                        if (match) begin
                            pred_n = nxt(lsfr_data);
                            bad_n  = '0;
                        end else begin
                            err_vld_n  = 1'b1;
                            err_cnt_n  = sat_inc(err_base);
                            err_flag_n = 1'b1;
                            // Flywheel: advance on our own prediction, not on corrupted data.
                            pred_n     = nxt(pred);
                            if (int'(bad_cnt) + 1 == LOSS_CNT) begin
                                bad_n   = BW'(LOSS_CNT);
                                state_n = SEED;
                            end else begin
                                bad_n = bad_cnt + BW'(1);
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pred     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            lock     <= 1'b0;
            err_vld  <= 1'b0;
            err_flag <= 1'b0;
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_n;
            pred     <= pred_n;
            good_cnt <= good_n;
            bad_cnt  <= bad_n;
            lock     <= (state_n == LOCKED);
            err_vld  <= err_vld_n;
            err_flag <= err_flag_n;
            err_cnt  <= err_cnt_n;
            word_cnt <= word_cnt_n;
        end
    end

endmodule

// File: tb/tb_lsfr_checker.sv
// Directed bench for lsfr_checker: a reference generator feeds a full-width instance
// and a narrow-counter instance that exposes counter saturation.
module tb_lsfr_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        lsfr_vld;
    logic [7:0]  lsfr_data;
    logic        clr_cnt;

    logic        lock, err_vld, err_flag;
    logic [15:0] err_cnt, word_cnt;
    logic        s_lock, s_err_vld, s_err_flag;
    logic [2:0]  s_err_cnt, s_word_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] gen;

    always #5 clk = ~clk;

    lsfr_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .lsfr_vld(lsfr_vld),
        .lsfr_data(lsfr_data), .clr_cnt(clr_cnt), .lock(lock),
        .err_vld(err_vld), .err_flag(err_flag), .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    lsfr_checker #(.CNT_WIDTH(3)) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .lsfr_vld(lsfr_vld),
        .lsfr_data(lsfr_data), .clr_cnt(clr_cnt), .lock(s_lock),
        .err_vld(s_err_vld), .err_flag(s_err_flag), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
    );

    // Reference generator: x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3.
    function automatic logic [7:0] gen_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one generator word (optionally corrupted), then sample 1 ns after the edge.
    task automatic send(input logic [7:0] flip, input logic clr);
        lsfr_vld  = 1'b1;
        lsfr_data = gen ^ flip;
        clr_cnt   = clr;
        gen       = gen_step(gen);
        @(posedge clk); #1;
        lsfr_vld  = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic idle(input logic clr);
        lsfr_vld = 1'b0;
        clr_cnt  = clr;
        @(posedge clk); #1;
        clr_cnt  = 1'b0;
    endtask

    task automatic relock(input string tag);
        for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
        chk({tag, "_lock_after4"}, 32'(lock), 32'd0);
        send(8'h00, 1'b0);
        chk({tag, "_lock_after5"}, 32'(lock), 32'd1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; lsfr_vld = 1'b0; lsfr_data = 8'h00; clr_cnt = 1'b0;
        gen = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_err_vld", 32'(err_vld), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);

        // Clean lock from seed FF: seed word + 4 matches.
        rst = 1'b0; enable = 1'b1;
        idle(1'b0);
        relock("clean");
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);
        chk("clean_word_cnt0", 32'(word_cnt), 32'd0);
        for (int i = 0; i < 6; i++) send(8'h00, 1'b0);
        chk("clean_word_cnt6", 32'(word_cnt), 32'd6);
        chk("clean_err_cnt6", 32'(err_cnt), 32'd0);

        // Single bit error, then flywheel keeps matching.
        send(8'h01, 1'b0);
        chk("sbe_err_vld", 32'(err_vld), 32'd1);
        chk("sbe_err_cnt", 32'(err_cnt), 32'd1);
        chk("sbe_err_flag", 32'(err_flag), 32'd1);
        chk("sbe_lock", 32'(lock), 32'd1);
        chk("sbe_word_cnt", 32'(word_cnt), 32'd7);
        send(8'h00, 1'b0);
        chk("sbe_err_vld_clr", 32'(err_vld), 32'd0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("fly_err_cnt", 32'(err_cnt), 32'd1);
        chk("fly_word_cnt", 32'(word_cnt), 32'd10);
        idle(1'b0);
        idle(1'b0);
        send(8'h00, 1'b0);
        chk("gap_err_cnt", 32'(err_cnt), 32'd1);
        chk("gap_word_cnt", 32'(word_cnt), 32'd11);
        chk("gap_lock", 32'(lock), 32'd1);

        // Standalone clear.
        idle(1'b1);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_word_cnt", 32'(word_cnt), 32'd0);
        chk("clr_err_flag", 32'(err_flag), 32'd0);

        // Loss of lock after 4 consecutive errors, then relock.
        for (int i = 0; i < 3; i++) send(8'h01, 1'b0);
        chk("loss_lock_after3", 32'(lock), 32'd1);
        send(8'h01, 1'b0);
        chk("loss_lock_after4", 32'(lock), 32'd0);
        chk("loss_err_cnt", 32'(err_cnt), 32'd4);
        chk("loss_word_cnt", 32'(word_cnt), 32'd4);
        relock("resync");
        chk("resync_err_cnt", 32'(err_cnt), 32'd4);

        // Alternating error/match: stays locked, narrow counters saturate at 7.
        for (int i = 0; i < 8; i++) begin
            send(8'h01, 1'b0);
            send(8'h00, 1'b0);
        end
        chk("alt_lock", 32'(lock), 32'd1);
        chk("alt_err_cnt", 32'(err_cnt), 32'd12);
        chk("alt_word_cnt", 32'(word_cnt), 32'd20);
        chk("sat_err_cnt", 32'(s_err_cnt), 32'd7);
        chk("sat_word_cnt", 32'(s_word_cnt), 32'd7);
        send(8'h01, 1'b0);
        chk("sat_err_hold", 32'(s_err_cnt), 32'd7);
        chk("sat_err_vld", 32'(s_err_vld), 32'd1);
        send(8'h00, 1'b0);

        // Clear together with an error word.
        send(8'h01, 1'b1);
        chk("clrerr_err_cnt", 32'(err_cnt), 32'd1);
        chk("clrerr_word_cnt", 32'(word_cnt), 32'd1);
        chk("clrerr_err_flag", 32'(err_flag), 32'd1);
        chk("clrerr_err_vld", 32'(err_vld), 32'd1);
        chk("clrerr_s_err_cnt", 32'(s_err_cnt), 32'd1);

        // Enable low for 3 cycles: lock drops, counters held.
        enable = 1'b0;
        send(8'h00, 1'b0);
        chk("en_lock", 32'(lock), 32'd0);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        chk("en_err_cnt", 32'(err_cnt), 32'd1);
        chk("en_word_cnt", 32'(word_cnt), 32'd1);
        chk("en_err_vld", 32'(err_vld), 32'd0);
        enable = 1'b1;
        idle(1'b0);

        // Zero word ignored in SEED, then a CHECK mismatch reseeds without counting.
        lsfr_vld = 1'b1; lsfr_data = 8'h00;
        @(posedge clk); #1;
        lsfr_vld = 1'b0;
        chk("zero_lock", 32'(lock), 32'd0);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        chk("chk_err_vld", 32'(err_vld), 32'd0);
        chk("chk_err_cnt", 32'(err_cnt), 32'd1);
        relock("reseed");
        chk("reseed_err_cnt", 32'(err_cnt), 32'd1);

        // Synchronous reset while locked.
        send(8'h01, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_lock", 32'(lock), 32'd0);
        chk("mrst_err_vld", 32'(err_vld), 32'd0);
        chk("mrst_err_flag", 32'(err_flag), 32'd0);
        chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mrst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0;
        idle(1'b0);
        relock("postrst");
        chk("postrst_word_cnt", 32'(word_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
